mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of every signal between the arbiter, its two clients (instruction
// fetch and data access) and the shared memory port.
//
// Handshake: a client holds its request level high until it sees its
// one-cycle ready pulse. The arbiter holds o_MEM_req and the command fields
// stable until it samples i_MEM_ready high, and it ignores i_MEM_ready
// whenever o_MEM_req is low.
//
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding system (clients plus memory).
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  // instruction-cache side
  logic            i_IC_DataReq;
  logic [XLEN-1:0] i_IC_Addr;
  logic            o_IC_MemReady;
  logic [XLEN-1:0] o_IC_Data;
  // data-memory side
  logic            i_DM_MemRead;
  logic            i_DM_Wen;
  logic [XLEN-1:0] i_DM_Addr;
  logic [XLEN-1:0] i_DM_Wd;
  logic [2:0]      i_DM_f3;
  logic            o_DM_data_ready;
  logic [XLEN-1:0] o_DM_ReadData;
  // shared memory port
  logic            o_MEM_req;
  logic            o_MEM_wen;
  logic [XLEN-1:0] o_MEM_addr;
  logic [XLEN-1:0] o_MEM_wd;
  logic [2:0]      o_MEM_f3;
  logic            i_MEM_ready;
  logic [XLEN-1:0] i_MEM_rdata;
  // watchdog
  logic            o_err;

  modport slave (
    input  i_IC_DataReq, i_IC_Addr,
    output o_IC_MemReady, o_IC_Data,
    input  i_DM_MemRead, i_DM_Wen, i_DM_Addr, i_DM_Wd, i_DM_f3,
    output o_DM_data_ready, o_DM_ReadData,
    output o_MEM_req, o_MEM_wen, o_MEM_addr, o_MEM_wd, o_MEM_f3,
    input  i_MEM_ready, i_MEM_rdata,
    output o_err
  );

  modport master (
    output i_IC_DataReq, i_IC_Addr,
    input  o_IC_MemReady, o_IC_Data,
    output i_DM_MemRead, i_DM_Wen, i_DM_Addr, i_DM_Wd, i_DM_f3,
    input  o_DM_data_ready, o_DM_ReadData,
    input  o_MEM_req, o_MEM_wen, o_MEM_addr, o_MEM_wd, o_MEM_f3,
    output i_MEM_ready, i_MEM_rdata,
    input  o_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter. Instruction fetch (IC) and data access (DM)
// share one memory port, and only one transaction is in flight at a time.
// Simultaneous requests alternate round-robin. An optional watchdog forces
// completion with data 0 and an error pulse when memory never answers.
//
// Timeline of one transaction:
//   edge N   : grant in IDLE, command registered, state -> BUSY_*
//   N..      : o_MEM_req high, command held stable
//   edge M   : i_MEM_ready (or watchdog) -> capture data, state -> RESP
//   M..M+1   : owner's ready pulse with the captured data
//   edge M+1 : back to IDLE (no grant on this edge)
//
// XLEN must match the XLEN of the connected mem_arbiter_if instance.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mem_arbiter_if.slave bus,
  output logic [1:0]   o_dbg_state
);

  // When the watchdog is disabled the counter is a single unused bit, because
  // a zero-width vector is not legal.
  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [2:0]    IC_F3    = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IC = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_last_dm;   // 1 = most recent grant went to DM
  logic            r_mem_req;
  logic            r_mem_wen;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wd;
  logic [2:0]      r_mem_f3;
  logic            r_ic_ready;
  logic            r_dm_ready;
  logic            r_err;
  logic [XLEN-1:0] r_ic_data;
  logic [XLEN-1:0] r_dm_data;
  logic [CW-1:0]   r_cnt;

  logic            w_ic_pend;
  logic            w_dm_pend;
  logic            w_grant_dm;
  logic            w_grant_ic;
  logic            w_timeout;
  logic            w_done;
  logic [XLEN-1:0] w_resp_data;

  // A read and a write raised together still count as one DM request, and
  // the write flag wins when the command is built.
  assign w_ic_pend = bus.i_IC_DataReq;
  assign w_dm_pend = bus.i_DM_MemRead | bus.i_DM_Wen;

  // DM wins a tie unless DM was granted last, so contending clients alternate.
  assign w_grant_dm = w_dm_pend & (~w_ic_pend | ~r_last_dm);
  assign w_grant_ic = w_ic_pend & ~w_grant_dm;

  // The counter holds the number of BUSY edges already seen without ready, so
  // the TIMEOUT-th BUSY edge is the one where it equals TIMEOUT-1.
  assign w_timeout = (TIMEOUT > 0) ? (r_cnt == CNT_LAST) : 1'b0;

  // A real response wins over a watchdog expiry on the same edge.
  assign w_done      = bus.i_MEM_ready | w_timeout;
  assign w_resp_data = bus.i_MEM_ready ? bus.i_MEM_rdata : '0;

  // Arbitration FSM with every output registered. Reset abandons any
  // in-flight transaction without a ready pulse.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_last_dm  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_wen  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
      r_mem_f3   <= '0;
      r_ic_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_err      <= 1'b0;
      r_ic_data  <= '0;
      r_dm_data  <= '0;
      r_cnt      <= '0;
    end else begin
      r_ic_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_dm || w_grant_ic) begin
            r_state    <= w_grant_dm ? BUSY_DM : BUSY_IC;
            r_last_dm  <= w_grant_dm;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_grant_dm ? bus.i_DM_Addr : bus.i_IC_Addr;
            r_mem_wd   <= w_grant_dm ? bus.i_DM_Wd : '0;
            r_mem_f3   <= w_grant_dm ? bus.i_DM_f3 : IC_F3;
            r_mem_wen  <= w_grant_dm & bus.i_DM_Wen;
            r_cnt      <= '0;
          end
        end
        BUSY_IC, BUSY_DM: begin
          if (w_done) begin
            r_state    <= RESP;
            r_mem_req  <= 1'b0;
            r_err      <= ~bus.i_MEM_ready;
            r_ic_ready <= (r_state == BUSY_IC);
            r_dm_ready <= (r_state == BUSY_DM);
            if (r_state == BUSY_DM) begin
              r_dm_data <= w_resp_data;
            end else begin
              r_ic_data <= w_resp_data;
            end
          end else if (TIMEOUT > 0) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_MEM_req       = r_mem_req;
  assign bus.o_MEM_wen       = r_mem_wen;
  assign bus.o_MEM_addr      = r_mem_addr;
  assign bus.o_MEM_wd        = r_mem_wd;
  assign bus.o_MEM_f3        = r_mem_f3;
  assign bus.o_IC_MemReady   = r_ic_ready;
  assign bus.o_IC_Data       = r_ic_data;
  assign bus.o_DM_data_ready = r_dm_ready;
  assign bus.o_DM_ReadData   = r_dm_data;
  assign bus.o_err           = r_err;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Two instances (watchdog off, and TIMEOUT=4) get the
// same stimulus. A transaction-level model predicts every output each cycle,
// a completion queue cross-checks each ready pulse, and directed scenarios
// pin the model with hand-computed literals.
module tb_mem_arbiter;
  localparam int XLEN = 32;
  localparam int NI   = 2;
  localparam int TO1  = 4;
  localparam int W    = XLEN + 2;
  localparam int CW   = 160;
  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_RESP = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic            ic_req;
  logic [XLEN-1:0] ic_addr;
  logic            dm_rd;
  logic            dm_wen;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wd;
  logic [2:0]      dm_f3;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  mem_arbiter_if #(.XLEN(XLEN)) bus0 ();
  mem_arbiter_if #(.XLEN(XLEN)) bus1 ();
  logic [1:0] dbg0;
  logic [1:0] dbg1;

  assign bus0.i_IC_DataReq = ic_req;
  assign bus0.i_IC_Addr    = ic_addr;
  assign bus0.i_DM_MemRead = dm_rd;
  assign bus0.i_DM_Wen     = dm_wen;
  assign bus0.i_DM_Addr    = dm_addr;
  assign bus0.i_DM_Wd      = dm_wd;
  assign bus0.i_DM_f3      = dm_f3;
  assign bus0.i_MEM_ready  = mem_ready;
  assign bus0.i_MEM_rdata  = mem_rdata;
  assign bus1.i_IC_DataReq = ic_req;
  assign bus1.i_IC_Addr    = ic_addr;
  assign bus1.i_DM_MemRead = dm_rd;
  assign bus1.i_DM_Wen     = dm_wen;
  assign bus1.i_DM_Addr    = dm_addr;
  assign bus1.i_DM_Wd      = dm_wd;
  assign bus1.i_DM_f3      = dm_f3;
  assign bus1.i_MEM_ready  = mem_ready;
  assign bus1.i_MEM_rdata  = mem_rdata;

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(0)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .bus(bus0), .o_dbg_state(dbg0)
  );
  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO1)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .bus(bus1), .o_dbg_state(dbg1)
  );

  typedef struct packed {
    logic            req;
    logic            wen;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wd;
    logic [2:0]      f3;
    logic            ic_rdy;
    logic            dm_rdy;
    logic            err;
    logic [XLEN-1:0] ic_d;
    logic [XLEN-1:0] dm_d;
  } obs_t;

  obs_t obs [NI];
  assign obs[0] = {bus0.o_MEM_req, bus0.o_MEM_wen, bus0.o_MEM_addr, bus0.o_MEM_wd,
                   bus0.o_MEM_f3, bus0.o_IC_MemReady, bus0.o_DM_data_ready, bus0.o_err,
                   bus0.o_IC_Data, bus0.o_DM_ReadData};
  assign obs[1] = {bus1.o_MEM_req, bus1.o_MEM_wen, bus1.o_MEM_addr, bus1.o_MEM_wd,
                   bus1.o_MEM_f3, bus1.o_IC_MemReady, bus1.o_DM_data_ready, bus1.o_err,
                   bus1.o_IC_Data, bus1.o_DM_ReadData};

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  function automatic void chk(string name, logic [CW-1:0] act, logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- transaction-level model ----------------
  typedef struct {
    int              phase;
    bit              own_dm;
    bit              last_dm;
    int              busy_n;
    bit              err;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wd;
    logic [2:0]      f3;
    bit              wen;
    logic [XLEN-1:0] ic_data;
    logic [XLEN-1:0] dm_data;
  } model_t;
  model_t m [NI];

  function automatic void model_reset(int i);
    m[i].phase   = P_IDLE;
    m[i].own_dm  = 1'b0;
    m[i].last_dm = 1'b0;
    m[i].busy_n  = 0;
    m[i].err     = 1'b0;
    m[i].addr    = '0;
    m[i].wd      = '0;
    m[i].f3      = '0;
    m[i].wen     = 1'b0;
    m[i].ic_data = '0;
    m[i].dm_data = '0;
  endfunction

  function automatic void finish_txn(int i, logic [XLEN-1:0] d, bit e);
    if (m[i].own_dm) m[i].dm_data = d;
    else             m[i].ic_data = d;
    m[i].err   = e;
    m[i].phase = P_RESP;
    if (i == 0) exp_q0.push_back({m[i].own_dm, e, d});
    else        exp_q1.push_back({m[i].own_dm, e, d});
  endfunction

  function automatic void model_step(int i);
    bit icp;
    bit dmp;
    bit pick_dm;
    int lim;
    lim = (i == 0) ? 0 : TO1;
    icp = ic_req;
    dmp = dm_rd | dm_wen;
    case (m[i].phase)
      P_IDLE: begin
        if (icp || dmp) begin
          pick_dm      = dmp && (!icp || !m[i].last_dm);
          m[i].own_dm  = pick_dm;
          m[i].last_dm = pick_dm;
          m[i].addr    = pick_dm ? dm_addr : ic_addr;
          m[i].wd      = pick_dm ? dm_wd : '0;
          m[i].f3      = pick_dm ? dm_f3 : 3'b010;
          m[i].wen     = pick_dm && dm_wen;
          m[i].busy_n  = 0;
          m[i].phase   = P_BUSY;
        end
      end
      P_BUSY: begin
        m[i].busy_n = m[i].busy_n + 1;
        if (mem_ready) finish_txn(i, mem_rdata, 1'b0);
        else if (lim > 0 && m[i].busy_n >= lim) finish_txn(i, '0, 1'b1);
      end
      default: m[i].phase = P_IDLE;
    endcase
  endfunction

  // Model advances on the same edge as the DUT, reading the stable inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) model_reset(i);
    end else begin
      for (int i = 0; i < NI; i++) model_step(i);
    end
  end

  function automatic obs_t model_obs(int i);
    obs_t e;
    e.req    = (m[i].phase == P_BUSY);
    e.wen    = m[i].wen;
    e.addr   = m[i].addr;
    e.wd     = m[i].wd;
    e.f3     = m[i].f3;
    e.ic_rdy = (m[i].phase == P_RESP) && !m[i].own_dm;
    e.dm_rdy = (m[i].phase == P_RESP) && m[i].own_dm;
    e.err    = (m[i].phase == P_RESP) && m[i].err;
    e.ic_d   = m[i].ic_data;
    e.dm_d   = m[i].dm_data;
    return e;
  endfunction

  function automatic void check_cycle(int i);
    obs_t a;
    obs_t e;
    string p;
    a = obs[i];
    e = model_obs(i);
    p = $sformatf("u%0d_", i);
    chk({p, "mem_req"}, a.req, e.req);
    chk({p, "ic_ready"}, a.ic_rdy, e.ic_rdy);
    chk({p, "dm_ready"}, a.dm_rdy, e.dm_rdy);
    chk({p, "err"}, a.err, e.err);
    chk({p, "ic_data"}, a.ic_d, e.ic_d);
    chk({p, "dm_data"}, a.dm_d, e.dm_d);
    if (e.req || !rst_n) begin
      chk({p, "mem_addr"}, a.addr, e.addr);
      chk({p, "mem_f3"}, a.f3, e.f3);
      chk({p, "mem_wen"}, a.wen, e.wen);
      if (e.wen || !rst_n) chk({p, "mem_wd"}, a.wd, e.wd);
    end
  endfunction

  // ---------------- monitors for directed literals ----------------
  int cyc = 0;
  int ic_pulses [NI] = '{0, 0};
  int dm_pulses [NI] = '{0, 0};
  int err_cnt   [NI] = '{0, 0};
  int err_rdy   [NI] = '{0, 0};
  bit prev_req  [NI] = '{0, 0};
  int wen_seen     = 0;
  int last_rdy_cyc = 0;
  int last_err_cyc = 0;
  logic [XLEN-1:0] rise_addr[$];
  int              rise_cyc[$];

  // Compare process: one sample per cycle, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      logic [W-1:0] got;
      logic [W-1:0] want;
      check_cycle(i);
      if (obs[i].ic_rdy || obs[i].dm_rdy) begin
        got  = {obs[i].dm_rdy, obs[i].err, obs[i].dm_rdy ? obs[i].dm_d : obs[i].ic_d};
        want = '1;
        if (i == 0 && exp_q0.size() > 0) want = exp_q0.pop_front();
        else if (i == 1 && exp_q1.size() > 0) want = exp_q1.pop_front();
        chk($sformatf("u%0d_sb_txn", i), got, want);
      end
      if (obs[i].ic_rdy) ic_pulses[i]++;
      if (obs[i].dm_rdy) dm_pulses[i]++;
      if (obs[i].err) err_cnt[i]++;
      if (obs[i].err && (obs[i].ic_rdy || obs[i].dm_rdy)) err_rdy[i]++;
      if (i == 1) begin
        if (obs[1].req && !prev_req[1]) begin
          rise_addr.push_back(obs[1].addr);
          rise_cyc.push_back(cyc);
        end
        if (obs[1].req && obs[1].wen) wen_seen++;
        if (obs[1].ic_rdy || obs[1].dm_rdy) last_rdy_cyc = cyc;
        if (obs[1].err) last_err_cyc = cyc;
      end
      prev_req[i] = obs[i].req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(int target, string name);
    for (int k = 0; k < 40 && int'(rise_cyc.size()) < target; k++) @(negedge clk);
    chk(name, (int'(rise_cyc.size()) >= target), 1);
  endtask

  task automatic pulse_ready(int d, logic [XLEN-1:0] data);
    tick(d);
    mem_ready = 1'b1;
    mem_rdata = data;
    tick(1);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n, p_ic, p_dm, p_ic0, p_dm0, w0, e1, er1, e0;
    ic_req = 0; ic_addr = '0; dm_rd = 0; dm_wen = 0; dm_addr = '0; dm_wd = '0;
    dm_f3 = '0; mem_ready = 0; mem_rdata = '0;
    #2 rst_n = 1'b0;
    tick(3);
    chk("reset_outputs_u0", obs[0], '0);
    chk("reset_outputs_u1", obs[1], '0);
    rst_n = 1'b1;
    tick(2);

    // IC fetch, memory answers 2 cycles after the request appears
    n = rise_cyc.size(); p_ic = ic_pulses[1]; p_dm = dm_pulses[1]; w0 = wen_seen;
    ic_addr = 32'h100; ic_req = 1'b1;
    wait_rise(n + 1, "t1_grant");
    ic_req = 1'b0;
    chk("t1_addr", bus1.o_MEM_addr, 32'h100);
    chk("t1_f3", bus1.o_MEM_f3, 3'b010);
    pulse_ready(2, 32'h0000_0013);
    tick(3);
    chk("t1_ic_pulses", ic_pulses[1] - p_ic, 1);
    chk("t1_dm_pulses", dm_pulses[1] - p_dm, 0);
    chk("t1_ic_data", bus1.o_IC_Data, 32'h13);
    chk("t1_wen_never", wen_seen - w0, 0);
    chk("t1_latency", last_rdy_cyc - rise_cyc[n], 3);

    // tie after reset goes to DM; IC held through RESP is granted next IDLE
    do_reset(2);
    tick(1);
    n = rise_cyc.size();
    ic_addr = 32'h140; ic_req = 1'b1;
    dm_addr = 32'h3000; dm_f3 = 3'b010; dm_rd = 1'b1;
    wait_rise(n + 1, "t2_first_grant");
    dm_rd = 1'b0;
    chk("t2_first_is_dm", rise_addr[n], 32'h3000);
    pulse_ready(0, 32'hAAAA_5555);
    wait_rise(n + 2, "t2_second_grant");
    ic_req = 1'b0;
    chk("t2_second_is_ic", rise_addr[n + 1], 32'h140);
    chk("t2_regrant_gap", rise_cyc[n + 1] - last_rdy_cyc, 2);
    pulse_ready(1, 32'h0000_1234);
    tick(3);
    chk("t2_dm_data", bus1.o_DM_ReadData, 32'hAAAA_5555);
    chk("t2_ic_data", bus1.o_IC_Data, 32'h1234);

    // DM write: command stays put even though the client inputs change
    n = rise_cyc.size(); p_dm = dm_pulses[1];
    dm_addr = 32'h2000; dm_wd = 32'hDEAD_BEEF; dm_f3 = 3'd2; dm_wen = 1'b1;
    wait_rise(n + 1, "t3_grant");
    dm_wen = 1'b0; dm_addr = 32'hFFFF_0000; dm_wd = '0; dm_f3 = 3'd5;
    tick(1);
    chk("t3_wen", bus1.o_MEM_wen, 1'b1);
    chk("t3_addr", bus1.o_MEM_addr, 32'h2000);
    chk("t3_wd", bus1.o_MEM_wd, 32'hDEAD_BEEF);
    chk("t3_f3", bus1.o_MEM_f3, 3'd2);
    pulse_ready(1, 32'h5A5A_0000);
    tick(3);
    chk("t3_dm_pulses", dm_pulses[1] - p_dm, 1);
    chk("t3_dm_data", bus1.o_DM_ReadData, 32'h5A5A_0000);

    // read and write together behave as a write
    n = rise_cyc.size();
    dm_addr = 32'h2004; dm_wd = 32'h11; dm_rd = 1'b1; dm_wen = 1'b1;
    wait_rise(n + 1, "t3b_grant");
    dm_rd = 1'b0; dm_wen = 1'b0;
    chk("t3b_wen", bus1.o_MEM_wen, 1'b1);
    pulse_ready(0, 32'h00C0_FFEE);
    tick(3);

    // memory ready while idle is ignored
    p_ic = ic_pulses[1]; p_dm = dm_pulses[1];
    mem_ready = 1'b1; mem_rdata = 32'h77;
    tick(3);
    mem_ready = 1'b0;
    tick(2);
    chk("t4_no_ic_pulse", ic_pulses[1] - p_ic, 0);
    chk("t4_no_dm_pulse", dm_pulses[1] - p_dm, 0);
    chk("t4_dm_data_held", bus1.o_DM_ReadData, 32'h00C0_FFEE);

    // watchdog: memory never answers
    n = rise_cyc.size(); e1 = err_cnt[1]; er1 = err_rdy[1]; e0 = err_cnt[0];
    ic_addr = 32'h400; ic_req = 1'b1;
    wait_rise(n + 1, "t5_grant");
    ic_req = 1'b0;
    for (int k = 0; k < 20 && err_cnt[1] == e1; k++) tick(1);
    chk("t5_err_pulse", err_cnt[1] - e1, 1);
    chk("t5_err_with_ready", err_rdy[1] - er1, 1);
    chk("t5_ic_data_zero", bus1.o_IC_Data, 32'h0);
    chk("t5_timeout_delay", last_err_cyc - rise_cyc[n], TO1);
    chk("t5_u0_still_busy", bus0.o_MEM_req, 1'b1);
    chk("t5_u0_no_err", err_cnt[0] - e0, 0);

    // reset in the middle of a DM transaction
    do_reset(2);
    tick(1);
    n = rise_cyc.size();
    dm_addr = 32'h2100; dm_rd = 1'b1;
    wait_rise(n + 1, "t6_grant");
    tick(1);
    p_ic = ic_pulses[1]; p_dm = dm_pulses[1]; p_ic0 = ic_pulses[0]; p_dm0 = dm_pulses[0];
    rst_n = 1'b0; dm_rd = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h99;
    #1;
    chk("t6_req_drop_u1", bus1.o_MEM_req, 1'b0);
    chk("t6_req_drop_u0", bus0.o_MEM_req, 1'b0);
    chk("t6_outputs_zero_u1", obs[1], '0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    mem_ready = 1'b0;
    chk("t6_no_pulse_u1", (ic_pulses[1] - p_ic) + (dm_pulses[1] - p_dm), 0);
    chk("t6_no_pulse_u0", (ic_pulses[0] - p_ic0) + (dm_pulses[0] - p_dm0), 0);
    n = rise_cyc.size();
    ic_addr = 32'h180; ic_req = 1'b1; dm_addr = 32'h2200; dm_rd = 1'b1;
    wait_rise(n + 1, "t6_tie_grant");
    ic_req = 1'b0; dm_rd = 1'b0;
    chk("t6_tie_is_dm", rise_addr[n], 32'h2200);
    pulse_ready(0, 32'h55);
    tick(3);
    chk("t6_dm_data", bus1.o_DM_ReadData, 32'h55);

    chk("sb_drain_u0", exp_q0.size(), 0);
    chk("sb_drain_u1", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop in case a scenario stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
